// File: rtl/writeback_unit.sv
// Writeback stage: retires instructions to the register file, waiting on
// variable-latency load data and flagging misaligned or timed-out loads.
module writeback_unit #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rd,
  input  logic [31:0]          in_alu_result,
  input  logic [31:0]          in_pc_plus4,
  input  logic                 in_mem_to_reg,
  input  logic                 in_reg_write,
  input  logic [1:0]           in_jump,
  input  logic [2:0]           in_funct3,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  output logic [4:0]           write_reg,
  output logic [31:0]          write_data,
  output logic                 reg_write,
  output logic                 load_err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] retired_count
);

  typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

  localparam int TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOAD_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [4:0]    r_rd;
  logic [2:0]    r_funct3;
  logic [1:0]    r_addr_lo;
  logic          r_rw;
  logic [TW-1:0] r_timer;

  logic          w_xfer;
  logic          w_misaligned;
  logic          w_timer_done;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_data;
  logic          w_reg_write;
  logic          w_load_err;
  logic [4:0]    w_write_reg;
  logic [31:0]   w_write_data;
  logic          w_retire;

  assign w_xfer       = in_valid & in_ready;
  assign w_timer_done = (r_timer == TIMER_LAST);

  always_comb begin
    w_misaligned = 1'b0;
    case (in_funct3)
      3'b001, 3'b101: w_misaligned = in_alu_result[0];
      3'b010:         w_misaligned = (in_alu_result[1:0] != 2'b00);
      3'b011, 3'b110, 3'b111: w_misaligned = 1'b1;
      default:        w_misaligned = 1'b0;
    endcase
  end

  // Memory returns the whole aligned word; pick the lane from the latched address.
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr_lo)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:
        if (w_xfer && in_mem_to_reg && !w_misaligned) w_state_next = WAIT_MEM;
      WAIT_MEM:
        if (mem_rvalid || w_timer_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; data and address hold when nothing retires.
  always_comb begin
    w_reg_write  = 1'b0;
    w_load_err   = 1'b0;
    w_write_reg  = write_reg;
    w_write_data = write_data;
    w_retire     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (!in_mem_to_reg) begin
            w_reg_write  = in_reg_write & (in_rd != 5'd0);
            w_write_reg  = in_rd;
            w_write_data = (in_jump != 2'b00) ? in_pc_plus4 : in_alu_result;
            w_retire     = 1'b1;
          end else if (w_misaligned) begin
            w_load_err = 1'b1;
            w_retire   = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          w_reg_write  = r_rw & (r_rd != 5'd0);
          w_write_reg  = r_rd;
          w_write_data = w_load_data;
          w_retire     = 1'b1;
        end else if (w_timer_done) begin
          w_load_err = 1'b1;
          w_retire   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd      <= 5'd0;
      r_funct3  <= 3'd0;
      r_addr_lo <= 2'd0;
      r_rw      <= 1'b0;
      r_timer   <= '0;
    end else if (r_state == IDLE) begin
      if (w_xfer && in_mem_to_reg && !w_misaligned) begin
        r_rd      <= in_rd;
        r_funct3  <= in_funct3;
        r_addr_lo <= in_alu_result[1:0];
        r_rw      <= in_reg_write;
        r_timer   <= '0;
      end
    end else if (!mem_rvalid && !w_timer_done) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready      <= 1'b1;
      busy          <= 1'b0;
      reg_write     <= 1'b0;
      load_err      <= 1'b0;
      write_reg     <= 5'd0;
      write_data    <= 32'd0;
      retired_count <= '0;
    end else begin
      in_ready   <= (w_state_next == IDLE);
      busy       <= (w_state_next == WAIT_MEM);
      reg_write  <= w_reg_write;
      load_err   <= w_load_err;
      write_reg  <= w_write_reg;
      write_data <= w_write_data;
      if (w_retire) retired_count <= retired_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU/jump writes, load formatting,
// misalignment, timeout, throughput and reset abort.
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic        in_mem_to_reg;
  logic        in_reg_write;
  logic [1:0]  in_jump;
  logic [2:0]  in_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic        load_err;
  logic        busy;
  logic [31:0] retired_count;

  int total;
  int bad;

  writeback_unit #(.LOAD_TIMEOUT(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_jump(in_jump), .in_funct3(in_funct3),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .load_err(load_err), .busy(busy), .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle transfer; outputs reflecting it are visible on return.
  task automatic applyStimulus(input logic [4:0] rd, input logic [31:0] alu,
                               input logic [31:0] pc4, input logic m2r,
                               input logic rw, input logic [1:0] jmp,
                               input logic [2:0] f3);
    in_rd = rd; in_alu_result = alu; in_pc_plus4 = pc4;
    in_mem_to_reg = m2r; in_reg_write = rw; in_jump = jmp; in_funct3 = f3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Return load data so that mem_rvalid is sampled 'delay' edges after the transfer.
  task automatic loadReturn(input logic [31:0] rdata, input int delay);
    for (int i = 1; i < delay; i++) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    int earlyErr;
    int readyLow;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_rd = '0; in_alu_result = '0; in_pc_plus4 = '0;
    in_mem_to_reg = 1'b0; in_reg_write = 1'b0; in_jump = '0; in_funct3 = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_reg_write", reg_write, 0);
    checkOutput("rst_write_reg", write_reg, 0);
    checkOutput("rst_write_data", write_data, 0);
    checkOutput("rst_load_err", load_err, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", retired_count, 0);
    rst = 1'b0;
    tick();

    applyStimulus(5'd5, 32'h0000_1234, 32'h0, 1'b0, 1'b1, 2'b00, 3'b000);
    checkOutput("alu_reg_write", reg_write, 1);
    checkOutput("alu_write_reg", write_reg, 5);
    checkOutput("alu_write_data", write_data, 32'h1234);
    checkOutput("alu_count", retired_count, 1);
    tick();
    checkOutput("alu_pulse_end", reg_write, 0);
    checkOutput("alu_data_hold", write_data, 32'h1234);

    applyStimulus(5'd1, 32'h0000_DEAD, 32'h0000_0104, 1'b0, 1'b1, 2'b01, 3'b000);
    checkOutput("jal_reg_write", reg_write, 1);
    checkOutput("jal_write_data", write_data, 32'h104);
    checkOutput("jal_count", retired_count, 2);
    applyStimulus(5'd0, 32'h0000_DEAD, 32'h0000_0104, 1'b0, 1'b1, 2'b01, 3'b000);
    checkOutput("jal_x0_reg_write", reg_write, 0);
    checkOutput("jal_x0_count", retired_count, 3);

    // LB at byte 3, data three edges after the transfer
    applyStimulus(5'd7, 32'h0000_1003, 32'h0, 1'b1, 1'b1, 2'b00, 3'b000);
    readyLow = (in_ready == 1'b0) ? 1 : 0;
    checkOutput("lb_busy", busy, 1);
    for (int i = 1; i < 3; i++) begin
      tick();
      if (in_ready == 1'b0) readyLow++;
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("lb_ready_low_cycles", readyLow, 3);
    checkOutput("lb_reg_write", reg_write, 1);
    checkOutput("lb_write_reg", write_reg, 7);
    checkOutput("lb_write_data", write_data, 32'hFFFF_FF80);
    checkOutput("lb_in_ready", in_ready, 1);
    checkOutput("lb_busy_done", busy, 0);
    checkOutput("lb_count", retired_count, 4);

    applyStimulus(5'd8, 32'h0000_1003, 32'h0, 1'b1, 1'b1, 2'b00, 3'b100);
    loadReturn(32'h80FF_0000, 3);
    checkOutput("lbu_write_data", write_data, 32'h0000_0080);
    checkOutput("lbu_count", retired_count, 5);

    applyStimulus(5'd9, 32'h0000_1002, 32'h0, 1'b1, 1'b1, 2'b00, 3'b001);
    loadReturn(32'h80FF_0000, 2);
    checkOutput("lh_write_data", write_data, 32'hFFFF_80FF);
    checkOutput("lh_count", retired_count, 6);

    applyStimulus(5'd10, 32'h0000_2000, 32'h0, 1'b1, 1'b1, 2'b00, 3'b010);
    loadReturn(32'h80FF_0000, 1);
    checkOutput("lw_write_data", write_data, 32'h80FF_0000);
    checkOutput("lw_write_reg", write_reg, 10);

    applyStimulus(5'd11, 32'h0000_2002, 32'h0, 1'b1, 1'b1, 2'b00, 3'b101);
    loadReturn(32'h80FF_0000, 1);
    checkOutput("lhu_write_data", write_data, 32'h0000_80FF);
    checkOutput("lhu_count", retired_count, 8);

    // Timeout: no data, error lands on the 16th edge after the transfer
    applyStimulus(5'd12, 32'h0000_0100, 32'h0, 1'b1, 1'b1, 2'b00, 3'b010);
    earlyErr = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (load_err != 1'b0 || reg_write != 1'b0 || busy != 1'b1) earlyErr++;
    end
    checkOutput("to_early", earlyErr, 0);
    tick();
    checkOutput("to_load_err", load_err, 1);
    checkOutput("to_reg_write", reg_write, 0);
    checkOutput("to_in_ready", in_ready, 1);
    checkOutput("to_busy", busy, 0);
    checkOutput("to_count", retired_count, 9);
    tick();
    checkOutput("to_err_pulse", load_err, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("stray_reg_write", reg_write, 0);
    checkOutput("stray_count", retired_count, 9);

    // Data on the same edge as the timeout wins
    applyStimulus(5'd13, 32'h0000_0200, 32'h0, 1'b1, 1'b1, 2'b00, 3'b010);
    loadReturn(32'hCAFE_BABE, 16);
    checkOutput("tie_reg_write", reg_write, 1);
    checkOutput("tie_load_err", load_err, 0);
    checkOutput("tie_write_data", write_data, 32'hCAFE_BABE);
    checkOutput("tie_count", retired_count, 10);

    applyStimulus(5'd14, 32'h0000_3002, 32'h0, 1'b1, 1'b1, 2'b00, 3'b010);
    checkOutput("mis_lw_load_err", load_err, 1);
    checkOutput("mis_lw_reg_write", reg_write, 0);
    checkOutput("mis_lw_in_ready", in_ready, 1);
    checkOutput("mis_lw_busy", busy, 0);
    checkOutput("mis_lw_count", retired_count, 11);
    applyStimulus(5'd14, 32'h0000_3001, 32'h0, 1'b1, 1'b1, 2'b00, 3'b001);
    checkOutput("mis_lh_load_err", load_err, 1);
    applyStimulus(5'd14, 32'h0000_3000, 32'h0, 1'b1, 1'b1, 2'b00, 3'b011);
    checkOutput("mis_f3_load_err", load_err, 1);
    checkOutput("mis_count", retired_count, 13);
    tick();
    checkOutput("mis_err_pulse", load_err, 0);

    // Back-to-back ALU ops with in_valid held high
    in_mem_to_reg = 1'b0; in_reg_write = 1'b1; in_jump = 2'b00; in_funct3 = 3'b000;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_rd = 5'(20 + i);
      in_alu_result = 32'(32'h11 * (i + 1));
      tick();
      checkOutput("b2b_reg_write", reg_write, 1);
      checkOutput("b2b_write_reg", write_reg, 64'(20 + i));
      checkOutput("b2b_write_data", write_data, 64'(32'h11 * (i + 1)));
    end
    in_valid = 1'b0;
    checkOutput("b2b_count", retired_count, 16);

    // Reset two cycles into WAIT_MEM aborts the load
    applyStimulus(5'd15, 32'h0000_0400, 32'h0, 1'b1, 1'b1, 2'b00, 3'b010);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort_reg_write", reg_write, 0);
    checkOutput("abort_load_err", load_err, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_count", retired_count, 0);
    #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("abort_late_rvalid", reg_write, 0);
    checkOutput("abort_late_count", retired_count, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
